instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameters: WIDTH, 32, address/PC width; INSTRUCTIONWIDTH, 16, instruction width; DEPTH, 4, prefetch buffer entries (power of 2, >=2); RESET_PC, 0, fetch PC after reset.
REQ-002 SHALL use one clock and an asynchronous active-low reset, with ports as follows:
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 imem_addr  output  WIDTH  instruction-port address; connects to memory a1.
REQ-006 imem_rdata  input  INSTRUCTIONWIDTH  instruction-port read data; connects to memory rd1; holds word at the address sampled on the previous rising edge.
REQ-007 redirect  input  1  flush the buffer and restart fetch at redirect_pc.
REQ-008 redirect_pc  input  WIDTH  new fetch PC, sampled when redirect=1.
REQ-009 instr_valid  output  1  instr/instr_pc hold a valid entry.
REQ-010 instr_ready  input  1  consumer accepts the entry.
REQ-011 instr  output  INSTRUCTIONWIDTH  head instruction.
REQ-012 instr_pc  output  WIDTH  word address of the head instruction.

Function
REQ-013 SHALL use word addressing: consecutive instructions at fetch_pc, fetch_pc+1, ..., with modulo 2^WIDTH wrap (all-ones+1 -> 0).
REQ-014 SHALL drive imem_addr = fetch_pc combinationally from the fetch_pc register at all times.
REQ-015 SHALL "issue" at a rising edge iff redirect=0 and (count + inflight) < DEPTH, where count = buffer occupancy before that edge; a simultaneous pop is not credited.
REQ-016 On issue, SHALL increment fetch_pc, set inflight=1 and latch issued_pc=fetch_pc; with no issue, SHALL leave fetch_pc unchanged and clear inflight.
REQ-017 SHALL, at the edge after an issue (inflight=1, redirect=0), push {imem_rdata, issued_pc} into the buffer tail.
REQ-018 Latency: address issued at edge k -> entry pushed at edge k+1 -> instr_valid=1 after edge k+1 when buffer was empty.
REQ-019 SHALL pop the head at an edge where instr_valid=1 and instr_ready=1; simultaneous push and pop SHALL leave count unchanged.
REQ-020 SHALL set instr_valid = (count != 0); instr/instr_pc SHALL be the head entry and hold stable while instr_valid=1 and instr_ready=0.
REQ-021 Buffer SHALL be a circular FIFO with DEPTH entries and wrapping read/write pointers; overflow is impossible by credit rule REQ-015.
REQ-022 Redirect (priority over issue, push and pop): at the edge with redirect=1, SHALL empty the buffer, discard any inflight response, clear inflight and load fetch_pc=redirect_pc; instr_valid=0 after that edge.
REQ-023 Redirect on consecutive cycles: the last one wins; no issue occurs while redirect=1.
REQ-024 Steady state with instr_ready held 1: SHALL deliver one instruction per cycle with no bubbles.
REQ-025 instr_ready=0 for a long time: SHALL fill to DEPTH entries, then hold fetch_pc constant until space frees.

Reset
REQ-026 While rst_n=0 (asynchronous assert): fetch_pc=RESET_PC, count=0, read/write pointers=0, inflight=0, instr_valid=0, instr=0, instr_pc=0, imem_addr=RESET_PC.
REQ-027 First issue SHALL occur at the first rising edge with rst_n=1; reset assertion mid-operation SHALL discard all buffered and inflight data.

Verification
REQ-028 Reset release, instr_ready=1, memory words 0..7 = 16'h1000+i -> instr_valid rises after the 2nd edge; instr_pc 0,1,2,... with instr 16'h1000,16'h1001,... on consecutive cycles.
REQ-029 instr_ready=0 from reset -> imem_addr stops at 4, count=4, head instr_pc=0 held stable; then instr_ready=1 -> pcs 0..3, then 4.. with no gap beyond one cycle and no duplicates.
REQ-030 Free-running at pc 5, redirect=1 with redirect_pc=17 for one cycle -> instr_valid=0 next cycle; next delivered instr_pc=17, no pc 5..8 delivered after the redirect.
REQ-031 Buffer full (instr_ready=0), redirect to 40 with instr_ready=1 the same cycle -> no pop counted, buffer empty, next delivered instr_pc=40.
REQ-032 rst_n pulsed low mid-stream at pc 9 -> instr_valid=0 immediately, imem_addr=0; after release fetch restarts at pc 0.
REQ-033 fetch_pc = all-ones via redirect -> delivered instr_pc all-ones then 0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word addresses to a one-cycle-latency instruction
// memory and queues the returned words in a small prefetch FIFO for the consumer.
module instr_fetch_unit #(
    parameter int                WIDTH            = 32,
    parameter int                INSTRUCTIONWIDTH = 16,
    parameter int                DEPTH            = 4,
    parameter logic [WIDTH-1:0]  RESET_PC         = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic [WIDTH-1:0]            imem_addr,
    input  logic [INSTRUCTIONWIDTH-1:0] imem_rdata,
    input  logic                        redirect,
    input  logic [WIDTH-1:0]            redirect_pc,
    output logic                        instr_valid,
    input  logic                        instr_ready,
    output logic [INSTRUCTIONWIDTH-1:0] instr,
    output logic [WIDTH-1:0]            instr_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0]            fetch_pc;
    logic [WIDTH-1:0]            issued_pc;
    logic                        inflight;
    logic [PW-1:0]               rd_ptr;
    logic [PW-1:0]               wr_ptr;
    logic [CW-1:0]               count;
    logic [CW-1:0]               count_next;
    logic [CW:0]                 credit;
    logic                        issue;
    logic                        push;
    logic                        pop;

    logic [INSTRUCTIONWIDTH-1:0] buf_instr [DEPTH];
    logic [WIDTH-1:0]            buf_pc    [DEPTH];

    // Handshake: an entry transfers at a rising edge where instr_valid=1 and
    // instr_ready=1; while instr_valid=1 and instr_ready=0 instr/instr_pc hold.
    // A redirect at the same edge overrides the transfer (nothing is consumed).

    // Inflight responses reserve a slot so the push one edge later always fits;
    // a pop at the issuing edge is deliberately not credited.
    assign credit    = (CW+1)'(count) + (CW+1)'(inflight);
    assign issue     = !redirect && (credit < (CW+1)'(DEPTH));
    assign push      = inflight && !redirect;
    assign pop       = instr_valid && instr_ready && !redirect;

    assign imem_addr   = fetch_pc;
    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? buf_instr[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? buf_pc[rd_ptr]    : '0;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc  <= RESET_PC;
            issued_pc <= '0;
            inflight  <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else if (redirect) begin
            fetch_pc  <= redirect_pc;
            inflight  <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc  <= fetch_pc + WIDTH'(1);
                issued_pc <= fetch_pc;
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_next;
        end
    end

    // Storage needs no reset: entries are only visible when count says so.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]    <= issued_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: per-cycle vector table plus hand-written
// sequences for mid-stream redirect and asynchronous reset.
module tb_instr_fetch_unit;

    localparam int W  = 32;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  imem_addr;
    logic [IW-1:0] imem_rdata = '0;
    logic          redirect = 1'b0;
    logic [W-1:0]  redirect_pc = '0;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [IW-1:0] instr;
    logic [W-1:0]  instr_pc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         ready;
        logic         redir;
        logic [W-1:0] rpc;
        logic         exp_valid;
        logic [W-1:0] exp_pc;
        logic [W-1:0] exp_addr;
    } vec_t;

    vec_t         vecs [25];
    logic [W-1:0] exp_q [$];

    instr_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc)
    );

    // Clock / memory model: word at address a is 16'h1000 + a (truncated).
    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mem_word(input logic [W-1:0] a);
        logic [IW-1:0] w;
        w = 16'h1000 + a[IW-1:0];
        return w;
    endfunction

    always @(posedge clk) imem_rdata <= mem_word(imem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic wait_for_pc(input logic [W-1:0] pc, input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (instr_valid && instr_pc == pc) found = 1'b1;
        end
        chk(name, W'(found), W'(1));
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 32'd0,         1'b0, 32'd0,         32'd1};
        vecs[1]  = '{1'b0, 1'b0, 32'd0,         1'b1, 32'd0,         32'd2};
        vecs[2]  = '{1'b0, 1'b0, 32'd0,         1'b1, 32'd0,         32'd3};
        vecs[3]  = '{1'b0, 1'b0, 32'd0,         1'b1, 32'd0,         32'd4};
        vecs[4]  = '{1'b0, 1'b0, 32'd0,         1'b1, 32'd0,         32'd4};
        vecs[5]  = '{1'b0, 1'b0, 32'd0,         1'b1, 32'd0,         32'd4};
        vecs[6]  = '{1'b1, 1'b0, 32'd0,         1'b1, 32'd1,         32'd4};
        vecs[7]  = '{1'b1, 1'b0, 32'd0,         1'b1, 32'd2,         32'd5};
        vecs[8]  = '{1'b1, 1'b0, 32'd0,         1'b1, 32'd3,         32'd6};
        vecs[9]  = '{1'b1, 1'b0, 32'd0,         1'b1, 32'd4,         32'd7};
        vecs[10] = '{1'b0, 1'b0, 32'd0,         1'b1, 32'd4,         32'd8};
        vecs[11] = '{1'b0, 1'b0, 32'd0,         1'b1, 32'd4,         32'd8};
        vecs[12] = '{1'b1, 1'b1, 32'd40,        1'b0, 32'd0,         32'd40};
        vecs[13] = '{1'b1, 1'b0, 32'd0,         1'b0, 32'd0,         32'd41};
        vecs[14] = '{1'b1, 1'b0, 32'd0,         1'b1, 32'd40,        32'd42};
        vecs[15] = '{1'b1, 1'b0, 32'd0,         1'b1, 32'd41,        32'd43};
        vecs[16] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'd0,         32'hFFFF_FFFF};
        vecs[17] = '{1'b1, 1'b0, 32'd0,         1'b0, 32'd0,         32'd0};
        vecs[18] = '{1'b1, 1'b0, 32'd0,         1'b1, 32'hFFFF_FFFF, 32'd1};
        vecs[19] = '{1'b1, 1'b0, 32'd0,         1'b1, 32'd0,         32'd2};
        vecs[20] = '{1'b1, 1'b0, 32'd0,         1'b1, 32'd1,         32'd3};
        vecs[21] = '{1'b1, 1'b1, 32'd100,       1'b0, 32'd0,         32'd100};
        vecs[22] = '{1'b1, 1'b1, 32'd200,       1'b0, 32'd0,         32'd200};
        vecs[23] = '{1'b1, 1'b0, 32'd0,         1'b0, 32'd0,         32'd201};
        vecs[24] = '{1'b1, 1'b0, 32'd0,         1'b1, 32'd200,       32'd202};

        // Reset state while rst_n is held low
        tick();
        tick();
        chk("rst_valid", W'(instr_valid), W'(0));
        chk("rst_addr",  imem_addr, 32'd0);
        chk("rst_instr", W'(instr), W'(0));
        chk("rst_pc",    instr_pc, 32'd0);
        rst_n = 1'b1;

        // Vector table: inputs applied for the next edge, outputs checked after it
        for (int i = 0; i < 25; i++) begin
            instr_ready = vecs[i].ready;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            tick();
            chk($sformatf("vec%0d_valid", i), W'(instr_valid), W'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d_pc", i), instr_pc, vecs[i].exp_pc);
                chk($sformatf("vec%0d_instr", i), W'(instr), W'(mem_word(vecs[i].exp_pc)));
            end
        end
        redirect = 1'b0;

        // Mid-stream redirect while pc 5 is at the head
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'd0;
        tick();
        redirect = 1'b0;
        wait_for_pc(32'd5, "reach_pc5");
        redirect    = 1'b1;
        redirect_pc = 32'd17;
        tick();
        redirect = 1'b0;
        chk("redir17_valid", W'(instr_valid), W'(0));
        chk("redir17_addr",  imem_addr, 32'd17);
        exp_q.push_back(32'd17);
        exp_q.push_back(32'd18);
        exp_q.push_back(32'd19);
        for (int i = 0; i < 12 && exp_q.size() != 0; i++) begin
            tick();
            if (instr_valid) begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                chk("redir17_pc", instr_pc, e);
                chk("redir17_instr", W'(instr), W'(mem_word(e)));
            end
        end
        chk("redir17_drained", W'(exp_q.size()), W'(0));

        // Asynchronous reset pulse mid-stream at pc 9
        redirect    = 1'b1;
        redirect_pc = 32'd0;
        tick();
        redirect = 1'b0;
        wait_for_pc(32'd9, "reach_pc9");
        rst_n = 1'b0;
        #1;
        chk("arst_valid", W'(instr_valid), W'(0));
        chk("arst_addr",  imem_addr, 32'd0);
        chk("arst_instr", W'(instr), W'(0));
        chk("arst_pc",    instr_pc, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rel_e1_valid", W'(instr_valid), W'(0));
        chk("rel_e1_addr",  imem_addr, 32'd1);
        tick();
        chk("rel_e2_valid", W'(instr_valid), W'(1));
        chk("rel_e2_pc",    instr_pc, 32'd0);
        chk("rel_e2_instr", W'(instr), W'(16'h1000));
        tick();
        chk("rel_e3_pc",    instr_pc, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
